data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and sequencer for `data_memory`: it accepts word read/write requests from two requesters, the load/store unit on port 0 and the debug/DMA port on port 1. It serializes them onto the memory's single address, read-enable and write-enable lines, and its shared tri-state 32-bit bus. It owns bus direction and read/write turnaround, so no other block drives `bus_io`. It sits between the core's memory-stage requesters and the `data_memory` instance.

## Interface
- `ADDR_WIDTH`, default 10: byte-address width shared with `data_memory`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `p0_req_i` in 1: port 0 request; held until granted.
- `p0_we_i` in 1: 1 = write, 0 = read.
- `p0_addr_i` in `ADDR_WIDTH`: byte address, must be word-aligned.
- `p0_wdata_i` in 32: write data.
- `p0_gnt_o` out 1: request accepted this cycle (combinational, IDLE only).
- `p0_rvalid_o` out 1: one-cycle pulse; `p0_rdata_o` valid.
- `p0_rdata_o` out 32: read data, held until the next read completes for this port.
- `p0_err_o` out 1: one-cycle pulse; a misaligned request was dropped.
- `p1_*`: identical set for port 1.
- `mem_addr_o` out `ADDR_WIDTH`: to `data_memory` `addr_i`.
- `mem_re_o` out 1: to `re_i`.
- `mem_we_o` out 1: to `we_i`.
- `mem_bus_io` inout 32: to `bus_io`; driven only in WRITE, otherwise high-Z.

## Operation
- States:
  - IDLE: may grant; no memory enables.
  - READ: `mem_re_o`=1, address applied.
  - WRITE: `mem_we_o`=1, bus driven with latched wdata.
  - TURN: all enables 0, bus high-Z.
- IDLE with a pending aligned request: grant the request, then latch port id, we, address and wdata at the clock edge.
  - Read goes to READ.
  - Write goes to WRITE if the previous memory access was not a read; otherwise it goes to TURN and then WRITE.
- READ → IDLE: `mem_bus_io` is sampled into the granted port's rdata register at the end of the READ cycle; that port's rvalid pulses in the following cycle.
- WRITE → IDLE: no response pulse; the grant is the completion.
- TURN → WRITE, unconditionally.
- Misaligned request (`addr[1:0]` != 0):
  - granted in IDLE and consumed; no memory access;
  - state stays IDLE; `pX_err_o` pulses the next cycle.
- `mem_addr_o` holds the latched address with bits [1:0] forced to 0. In IDLE it holds the last value.
- Simultaneous requests in IDLE are resolved per Configuration. The loser stays pending, and exactly one `gnt` is high per cycle.
- A requester may drop `req` before it is granted; that is not an error.
- Reset values:
  - state IDLE;
  - all `gnt`, `rvalid`, `err`, `mem_re_o` and `mem_we_o` outputs 0;
  - `rdata` 0, `mem_addr_o` 0, bus high-Z;
  - "last access was read" flag 0; round-robin pointer favours port 0.
- Reset asserted mid-transaction: the transaction is aborted with no rvalid. Enables are 0 and the bus is high-Z from the cycle after the reset edge.

## Timing
- Read latency: accept edge E0 → READ cycle → `rvalid` high in the cycle after edge E1, i.e. 2 cycles after the grant.
- Write latency: the write lands on edge E1, or on edge E2 when a turnaround is needed.
- Throughput: one access per 2 cycles; a read followed by a write costs 3 cycles.
- `rvalid` of transaction N may coincide with the IDLE grant of transaction N+1.
- The bus is never driven while `mem_re_o`=1, and is never driven in the cycle immediately after READ.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - On a collision, the port not granted most recently wins.
  - The pointer updates on every grant, including misaligned ones.
- Undefined: fixed priority; port 0 always wins collisions. Port 1 may starve and the pointer logic is absent.

## Test plan
- Port 0 reads address 0x004 after a prior write of 0xDEEDFEED to 0x004:
  - `p0_gnt_o` is high in the request cycle;
  - `mem_re_o`=1 for exactly 1 cycle with `mem_addr_o`=0x004;
  - `p0_rvalid_o` pulses 2 cycles after the grant with `p0_rdata_o`=0xDEEDFEED.
- Port 1 reads 0x008, then immediately writes 0x12345678 to 0x008:
  - one TURN cycle occurs, with enables 0 and the bus high-Z;
  - `mem_we_o`=1 with `mem_bus_io`=0x12345678 for 1 cycle;
  - readback returns 0x12345678.
- Both ports request reads every cycle for 8 accesses:
  - with the macro: grants alternate 0,1,0,1;
  - without the macro: only port 0 is granted and port 1 stays pending.
- Port 0 reads address 0x006:
  - `p0_gnt_o` is high, `p0_err_o` pulses one cycle later;
  - `mem_re_o` and `mem_we_o` stay 0 and no `rvalid` is issued.
- `rst_n` goes low during the WRITE cycle:
  - next cycle: `mem_we_o`=0, the bus is high-Z and no outputs pulse;
  - after release, the first grant goes to port 0.
- Bus-contention checker over all of the above: `mem_bus_io` is never driven by the arbiter while `mem_re_o`=1 or in the cycle following READ.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for data_memory: serializes word requests onto one memory port and owns the shared bus.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  localparam int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_W-1:0]     p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [DATA_W-1:0]     p0_rdata_o,
  output logic                  p0_err_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_W-1:0]     p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_W-1:0]     p1_rdata_o,
  output logic                  p1_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  inout  wire  [DATA_W-1:0]     mem_bus_io
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_TURN} state_t;

  state_t                r_state;
  logic                  r_port;
  logic                  r_last_rd;
  logic                  r_bus_oe;
  logic                  r_mem_re;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_p0_rvalid;
  logic                  r_p1_rvalid;
  logic                  r_p0_err;
  logic                  r_p1_err;
  logic [DATA_W-1:0]     r_p0_rdata;
  logic [DATA_W-1:0]     r_p1_rdata;

  logic                  w_can_gnt;
  logic                  w_win1;
  logic                  w_gnt_any;
  logic                  w_sel;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic                  w_misal;

  // Collision resolution: port 1 wins only when it alone requests or it is its turn
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_gnt;
  assign w_win1 = p1_req_i & (~p0_req_i | ~r_last_gnt);
`else
  assign w_win1 = p1_req_i & ~p0_req_i;
`endif

  assign w_can_gnt = rst_n & (r_state == ST_IDLE);
  assign p0_gnt_o  = w_can_gnt & p0_req_i & ~w_win1;
  assign p1_gnt_o  = w_can_gnt & w_win1;
  assign w_gnt_any = p0_gnt_o | p1_gnt_o;
  assign w_sel     = p1_gnt_o;
  assign w_we      = w_sel ? p1_we_i    : p0_we_i;
  assign w_addr    = w_sel ? p1_addr_i  : p0_addr_i;
  assign w_wdata   = w_sel ? p1_wdata_i : p0_wdata_i;
  assign w_misal   = |w_addr[1:0];

  assign mem_addr_o  = r_mem_addr;
  assign mem_re_o    = r_mem_re;
  assign mem_we_o    = r_mem_we;
  assign mem_bus_io  = r_bus_oe ? r_wdata : {DATA_W{1'bz}};
  assign p0_rvalid_o = r_p0_rvalid;
  assign p1_rvalid_o = r_p1_rvalid;
  assign p0_err_o    = r_p0_err;
  assign p1_err_o    = r_p1_err;
  assign p0_rdata_o  = r_p0_rdata;
  assign p1_rdata_o  = r_p1_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_port      <= 1'b0;
      r_last_rd   <= 1'b0;
      r_bus_oe    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_wdata     <= '0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_err    <= 1'b0;
      r_p1_err    <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_gnt  <= 1'b1;
`endif
    end else begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_err    <= 1'b0;
      r_p1_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_any) begin
`ifdef ARB_ROUND_ROBIN_EN
            r_last_gnt <= w_sel;
`endif
            if (w_misal) begin
              r_p0_err <= ~w_sel;
              r_p1_err <= w_sel;
            end else begin
              r_port     <= w_sel;
              r_mem_addr <= {w_addr[ADDR_WIDTH-1:2], 2'b00};
              r_wdata    <= w_wdata;
              if (w_we) begin
                r_last_rd <= 1'b0;
                // A write right after a read needs one dead cycle before the bus turns around
                if (r_last_rd) begin
                  r_state <= ST_TURN;
                end else begin
                  r_state  <= ST_WRITE;
                  r_mem_we <= 1'b1;
                  r_bus_oe <= 1'b1;
                end
              end else begin
                r_last_rd <= 1'b1;
                r_state   <= ST_READ;
                r_mem_re  <= 1'b1;
              end
            end
          end
        end
        ST_READ: begin
          r_state  <= ST_IDLE;
          r_mem_re <= 1'b0;
          if (r_port) begin
            r_p1_rdata  <= mem_bus_io;
            r_p1_rvalid <= 1'b1;
          end else begin
            r_p0_rdata  <= mem_bus_io;
            r_p0_rvalid <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_state  <= ST_IDLE;
          r_mem_we <= 1'b0;
          r_bus_oe <= 1'b0;
        end
        ST_TURN: begin
          r_state  <= ST_WRITE;
          r_mem_we <= 1'b1;
          r_bus_oe <= 1'b1;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          r_bus_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: a transaction-level model predicts grants, memory strobes, bus and responses per cycle.
module tb_data_mem_arbiter;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req_i = 1'b0, p0_we_i = 1'b0;
  logic [AW-1:0] p0_addr_i = '0;
  logic [DW-1:0] p0_wdata_i = '0;
  logic          p0_gnt_o, p0_rvalid_o, p0_err_o;
  logic [DW-1:0] p0_rdata_o;
  logic          p1_req_i = 1'b0, p1_we_i = 1'b0;
  logic [AW-1:0] p1_addr_i = '0;
  logic [DW-1:0] p1_wdata_i = '0;
  logic          p1_gnt_o, p1_rvalid_o, p1_err_o;
  logic [DW-1:0] p1_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_re_o, mem_we_o;
  wire  [DW-1:0] mem_bus_io;

  // Behavioural data_memory: drives the bus while re is high, captures it on the edge while we is high
  logic [DW-1:0] mem [NW] = '{default: '0};
  logic [DW-1:0] w_rd;
  assign w_rd = mem[mem_addr_o[AW-1:2]];
  assign mem_bus_io = mem_re_o ? w_rd : {DW{1'bz}};
  always @(posedge clk) if (mem_we_o) mem[mem_addr_o[AW-1:2]] <= mem_bus_io;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o), .p0_err_o(p0_err_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o), .p1_err_o(p1_err_o),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_bus_io(mem_bus_io)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: cycle numbers at which each scheduled event is due
  int            cyc = 0;
  bit            rst_pend = 1'b1;
  int            free_cyc, re_cyc, we_cyc, rv_cyc, err_cyc, rv_port, err_port;
  bit            last_rd, last_gnt;
  logic [DW-1:0] rv_data, we_data;
  logic [DW-1:0] exp_rdata [2];
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] ref_mem [NW];

  // Requester state
  bit            pend [2];
  bit            pwe [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pwd [2];
  bit            rand_en = 1'b0, rearm = 1'b0, rst_on_we = 1'b0;
  int            n_gnt [2];
  int            first_gnt = -1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit bus_hiz(input logic [DW-1:0] v);
    return (v === {DW{1'bz}}) || (v === '0);
  endfunction

  task automatic model_reset();
    free_cyc = cyc; re_cyc = -1; we_cyc = -1; rv_cyc = -1; err_cyc = -1;
    rv_port = 0; err_port = 0; last_rd = 1'b0; last_gnt = 1'b1;
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_addr = '0;
  endtask

  task automatic check_outputs();
    if (rv_cyc == cyc) exp_rdata[rv_port] = rv_data;
    chk("mem_re", 32'(mem_re_o), 32'(re_cyc == cyc));
    chk("mem_we", 32'(mem_we_o), 32'(we_cyc == cyc));
    chk("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
    chk("p0_rvalid", 32'(p0_rvalid_o), 32'(rv_cyc == cyc && rv_port == 0));
    chk("p1_rvalid", 32'(p1_rvalid_o), 32'(rv_cyc == cyc && rv_port == 1));
    chk("p0_err", 32'(p0_err_o), 32'(err_cyc == cyc && err_port == 0));
    chk("p1_err", 32'(p1_err_o), 32'(err_cyc == cyc && err_port == 1));
    chk("p0_rdata", p0_rdata_o, exp_rdata[0]);
    chk("p1_rdata", p1_rdata_o, exp_rdata[1]);
    if (we_cyc == cyc)      chk("bus_wr", mem_bus_io, we_data);
    else if (re_cyc == cyc) chk("bus_rd", mem_bus_io, rv_data);
    else                    chk("bus_hiz", 32'(bus_hiz(mem_bus_io)), 32'd1);
  endtask

  task automatic drive_stim();
    rst_n = 1'(cyc > 3);
    if (rst_on_we && we_cyc == cyc) begin
      rst_n = 1'b0;
      rst_on_we = 1'b0;
    end
    if (rand_en) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[p]  = 1'b1;
            pwe[p]   = 1'($urandom_range(0, 1));
            paddr[p] = AW'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) paddr[p][1:0] = 2'($urandom_range(1, 3));
            pwd[p]   = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          pend[p] = 1'b0;
        end
      end
    end
    p0_req_i = pend[0]; p0_we_i = pwe[0]; p0_addr_i = paddr[0]; p0_wdata_i = pwd[0];
    p1_req_i = pend[1]; p1_we_i = pwe[1]; p1_addr_i = paddr[1]; p1_wdata_i = pwd[1];
  endtask

  task automatic model_accept(input int w, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int idx;
    idx = int'(a[AW-1:2]);
    if (a[1:0] != 2'b00) begin
      err_cyc = cyc + 1; err_port = w; free_cyc = cyc + 1;
    end else begin
      exp_addr = a;
      if (we) begin
        ref_mem[idx] = d; we_data = d;
        we_cyc   = last_rd ? cyc + 2 : cyc + 1;
        free_cyc = we_cyc + 1;
        last_rd  = 1'b0;
      end else begin
        re_cyc = cyc + 1; rv_cyc = cyc + 2; rv_port = w; rv_data = ref_mem[idx];
        free_cyc = cyc + 2;
        last_rd  = 1'b1;
      end
    end
  endtask

  task automatic grant_phase();
    int  w;
    bit  obs [2];
    w = -1;
    if (!rst_n) begin
      rst_pend = 1'b1;
    end else if (cyc >= free_cyc) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (p0_req_i && p1_req_i) w = last_gnt ? 0 : 1;
`else
      if (p0_req_i && p1_req_i) w = 0;
`endif
      else if (p0_req_i) w = 0;
      else if (p1_req_i) w = 1;
    end
    chk("p0_gnt", 32'(p0_gnt_o), 32'(w == 0));
    chk("p1_gnt", 32'(p1_gnt_o), 32'(w == 1));
    if (w == 0) model_accept(0, p0_we_i, p0_addr_i, p0_wdata_i);
    if (w == 1) model_accept(1, p1_we_i, p1_addr_i, p1_wdata_i);
    if (w >= 0) last_gnt = 1'(w);
    obs[0] = p0_gnt_o; obs[1] = p1_gnt_o;
    for (int p = 0; p < 2; p++) begin
      if (obs[p]) begin
        n_gnt[p]++;
        if (first_gnt < 0) first_gnt = p;
        if (rearm && (n_gnt[0] + n_gnt[1] < 8)) begin
          pwe[p] = 1'b0;
          paddr[p] = AW'($urandom_range(0, 15) * 4);
        end else begin
          pend[p] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rst_pend) begin
      model_reset();
      rst_pend = 1'b0;
    end
    check_outputs();
    drive_stim();
    #1;
    grant_phase();
  endtask

  task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwd[p] = d;
    for (int i = 0; i < 40 && pend[p]; i++) step();
    chk("issue_timeout", 32'(pend[p]), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (pend[0] || pend[1]); i++) step();
    chk("drain_timeout", 32'(pend[0] | pend[1]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(NW); i++) ref_mem[i] = '0;
    model_reset();
    repeat (6) step();

    issue(0, 1'b1, 10'h004, 32'hDEEDFEED);
    issue(0, 1'b0, 10'h004, '0);
    repeat (3) step();
    chk("p0_read_deed", p0_rdata_o, 32'hDEEDFEED);

    issue(1, 1'b0, 10'h008, '0);
    issue(1, 1'b1, 10'h008, 32'h12345678);
    issue(1, 1'b0, 10'h008, '0);
    repeat (3) step();
    chk("p1_readback", p1_rdata_o, 32'h12345678);

    n_gnt[0] = 0; n_gnt[1] = 0; rearm = 1'b1;
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 10'h010;
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 10'h014;
    for (int i = 0; i < 60 && (n_gnt[0] + n_gnt[1] < 8); i++) step();
    rearm = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    chk("coll_p0_cnt", 32'(n_gnt[0]), 32'd4);
    chk("coll_p1_cnt", 32'(n_gnt[1]), 32'd4);
`else
    chk("coll_p0_cnt", 32'(n_gnt[0]), 32'd8);
    chk("coll_p1_cnt", 32'(n_gnt[1]), 32'd0);
    chk("coll_p1_pending", 32'(p1_req_i), 32'd1);
`endif
    drain();
    repeat (2) step();

    issue(0, 1'b0, 10'h006, '0);
    repeat (3) step();

    issue(0, 1'b1, 10'h020, 32'hCAFEF00D);
    rst_on_we = 1'b1;
    for (int i = 0; i < 5 && rst_on_we; i++) step();
    chk("rst_in_write", 32'(rst_on_we), 32'd0);
    first_gnt = -1;
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 10'h020;
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 10'h024;
    drain();
    chk("rst_first_gnt", 32'(first_gnt), 32'd0);
    repeat (3) step();

    rand_en = 1'b1;
    repeat (1500) step();
    rand_en = 1'b0;
    drain();
    repeat (4) step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
